// File: rtl/project_pkg.sv
// Shared types and ASCII constants for the matrix UART sender.
// The element type, FSM states and item kinds are defined here so every file agrees on them.
package project_pkg;

    localparam int ELEM_W = 8;
    typedef logic signed [ELEM_W-1:0] matrix_element_t;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] HASH  = 8'h23;

    // Longest string is "Total:-128" CR LF.
    localparam int BUF_DEPTH = 12;
    localparam logic [47:0] TOTAL_STR = "Total:";

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    typedef enum logic [2:0] {
        K_NEWLINE,
        K_ID,
        K_SUM_HEAD,
        K_SUM_ELEM,
        K_PLAIN
    } item_kind_t;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return {4'h3, d};
    endfunction

endpackage

// File: rtl/elem_to_dec.sv
// Combinational split of a signed element into sign, three decimal digits and
// the count of significant digits (1..3).
module elem_to_dec
    import project_pkg::*;
(
    input  matrix_element_t elem,
    output logic            neg,
    output logic [3:0]      hundreds,
    output logic [3:0]      tens,
    output logic [3:0]      ones,
    output logic [1:0]      ndigits
);

    logic [7:0] mag;
    logic [6:0] rem;

    always_comb begin
        neg = elem[ELEM_W-1];
        // -(-128) wraps to 8'h80, which read unsigned is the wanted magnitude 128.
        mag = neg ? $unsigned(-elem) : $unsigned(elem);

        hundreds = (mag >= 8'd100) ? 4'd1 : 4'd0;
        rem      = (mag >= 8'd100) ? 7'(mag - 8'd100) : mag[6:0];

        tens = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (rem >= 7'(10 * i)) begin
                tens = 4'(i);
            end
        end
        ones = 4'(rem - 7'd10 * {3'd0, tens});

        ndigits = (hundreds != 4'd0) ? 2'd3 : ((tens != 4'd0) ? 2'd2 : 2'd1);
    end

endmodule

// File: rtl/matrix_uart_sender.sv
// Formats one matrix item (element, ID, summary entry or line break) as ASCII
// and streams it byte by byte over a valid/ready interface to a UART transmitter.
module matrix_uart_sender
    import project_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            sender_start,
    input  matrix_element_t sender_data,
    input  logic            sender_last_col,
    input  logic            sender_newline,
    input  logic            sender_id,
    input  logic            sender_sum_head,
    input  logic            sender_sum_elem,
    input  logic            tx_ready,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    output logic            sender_busy,
    output logic            drop_err
);

    // Handshake: a byte moves only on a cycle with tx_valid && tx_ready; once
    // tx_valid rises it stays high with tx_data frozen until that cycle.

    state_t          state_q, state_d;
    matrix_element_t data_q, data_d;
    item_kind_t      kind_q, kind_d;
    logic            last_col_q, last_col_d;
    logic [7:0]      buf_q [BUF_DEPTH];
    logic [7:0]      buf_d [BUF_DEPTH];
    logic [3:0]      len_q, len_d;
    logic [3:0]      idx_q, idx_d;
    logic            drop_err_q, drop_err_d;
    logic [3:0]      p;

    logic       dec_neg;
    logic [3:0] dec_h, dec_t, dec_o;
    logic [1:0] dec_n;

    elem_to_dec u_dec (
        .elem     (data_q),
        .neg      (dec_neg),
        .hundreds (dec_h),
        .tens     (dec_t),
        .ones     (dec_o),
        .ndigits  (dec_n)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        kind_d     = kind_q;
        last_col_d = last_col_q;
        buf_d      = buf_q;
        len_d      = len_q;
        idx_d      = idx_q;
        p          = 4'd0;
        drop_err_d = sender_start && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (sender_start) begin
                    data_d     = sender_data;
                    last_col_d = sender_last_col;
                    if (sender_newline)       kind_d = K_NEWLINE;
                    else if (sender_id)       kind_d = K_ID;
                    else if (sender_sum_head) kind_d = K_SUM_HEAD;
                    else if (sender_sum_elem) kind_d = K_SUM_ELEM;
                    else                      kind_d = K_PLAIN;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (kind_q == K_NEWLINE) begin
                    buf_d[0] = CR;
                    buf_d[1] = LF;
                    p        = 4'd2;
                end else begin
                    if (kind_q == K_ID) begin
                        buf_d[p] = HASH;
                        p        = p + 4'd1;
                    end else if (kind_q == K_SUM_HEAD) begin
                        for (int i = 0; i < 6; i++) begin
                            buf_d[p] = TOTAL_STR[8*(5-i) +: 8];
                            p        = p + 4'd1;
                        end
                    end
                    if (dec_neg) begin
                        buf_d[p] = MINUS;
                        p        = p + 4'd1;
                    end
                    if (dec_n == 2'd3) begin
                        buf_d[p] = digit_ascii(dec_h);
                        p        = p + 4'd1;
                    end
                    if (dec_n >= 2'd2) begin
                        buf_d[p] = digit_ascii(dec_t);
                        p        = p + 4'd1;
                    end
                    buf_d[p] = digit_ascii(dec_o);
                    p        = p + 4'd1;
                    // ID and total lines always end the row; list entries never do.
                    if ((kind_q == K_ID) || (kind_q == K_SUM_HEAD) ||
                        ((kind_q == K_PLAIN) && last_col_q)) begin
                        buf_d[p] = CR;
                        p        = p + 4'd1;
                        buf_d[p] = LF;
                        p        = p + 4'd1;
                    end else begin
                        buf_d[p] = SPACE;
                        p        = p + 4'd1;
                    end
                end
                len_d   = p;
                idx_d   = 4'd0;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_q == len_q - 4'd1) begin
                        idx_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            kind_q     <= K_PLAIN;
            last_col_q <= 1'b0;
            len_q      <= 4'd0;
            idx_q      <= 4'd0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            kind_q     <= kind_d;
            last_col_q <= last_col_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Buffer contents are reloaded before every send, so they need no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign tx_valid    = (state_q == ST_SEND);
    assign tx_data     = tx_valid ? buf_q[idx_q] : 8'h00;
    assign sender_busy = (state_q != ST_IDLE);
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_matrix_uart_sender.sv
// Scoreboard bench for matrix_uart_sender: directed cases plus randomized items
// checked against a string-formatting reference model.
module tb_matrix_uart_sender;

    logic              clk = 1'b0;
    logic              rst;
    logic              sender_start;
    logic signed [7:0] sender_data;
    logic              sender_last_col;
    logic              sender_newline;
    logic              sender_id;
    logic              sender_sum_head;
    logic              sender_sum_elem;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              sender_busy;
    logic              drop_err;

    matrix_uart_sender dut (
        .clk             (clk),
        .rst             (rst),
        .sender_start    (sender_start),
        .sender_data     (sender_data),
        .sender_last_col (sender_last_col),
        .sender_newline  (sender_newline),
        .sender_id       (sender_id),
        .sender_sum_head (sender_sum_head),
        .sender_sum_elem (sender_sum_elem),
        .tx_ready        (tx_ready),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .sender_busy     (sender_busy),
        .drop_err        (drop_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         hs_count = 0;
    bit         rand_ready = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the item rendered through ordinary decimal formatting.
    function automatic void model_item(input logic signed [7:0] d, input bit nl, input bit id,
                                       input bit head, input bit elem, input bit lastc);
        string num;
        string s;
        if (nl) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            return;
        end
        num = $sformatf("%0d", d);
        if (id)        s = {"#", num};
        else if (head) s = {"Total:", num};
        else           s = num;
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (id || head || (!elem && lastc)) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            exp_q.push_back(8'h20);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check("stall_valid_held", tx_valid, 1);
                check("stall_data_held", tx_data, stall_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no byte at %0t", tx_data, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("byte", tx_data, mon_exp);
                end
                hs_count++;
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Random back-pressure driver, enabled only in the random phase.
    always begin
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic signed [7:0] d, input bit nl, input bit id,
                         input bit head, input bit elem, input bit lastc);
        sender_data     = d;
        sender_newline  = nl;
        sender_id       = id;
        sender_sum_head = head;
        sender_sum_elem = elem;
        sender_last_col = lastc;
        sender_start    = 1'b1;
        model_item(d, nl, id, head, elem, lastc);
        tick();
        sender_start    = 1'b0;
        // Junk on data/flags without a start must not matter.
        sender_data     = 8'($urandom);
        sender_newline  = 1'($urandom);
        sender_id       = 1'($urandom);
        sender_sum_head = 1'($urandom);
        sender_sum_elem = 1'($urandom);
        sender_last_col = 1'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sender_busy && n < 300) begin
            tick();
            n++;
        end
        check(name, sender_busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int n;
        rst             = 1'b1;
        sender_start    = 1'b0;
        sender_data     = 8'd0;
        sender_last_col = 1'b0;
        sender_newline  = 1'b0;
        sender_id       = 1'b0;
        sender_sum_head = 1'b0;
        sender_sum_elem = 1'b0;
        tx_ready        = 1'b1;
        repeat (3) tick();

        check("reset_tx_valid", tx_valid, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_busy", sender_busy, 0);
        check("reset_drop_err", drop_err, 0);
        rst = 1'b0;
        tick();

        // Plain 5: latency and cost of a two-byte item.
        issue(8'd5, 0, 0, 0, 0, 0);
        check("busy_at_n1", sender_busy, 1);
        tick();
        check("valid_at_n2", tx_valid, 1);
        check("first_byte_at_n2", tx_data, 8'h35);
        tick();
        tick();
        check("idle_at_n4", sender_busy, 0);

        // Most negative value, end of row.
        issue(8'h80, 0, 0, 0, 0, 1);
        wait_idle("idle_neg128");

        // Kind priority.
        issue(8'd7, 0, 0, 1, 1, 0);
        wait_idle("idle_sum_head_prio");
        issue(8'd3, 1, 1, 0, 0, 0);
        wait_idle("idle_newline_prio");

        // ID 0 with a ten-cycle stall on the first byte.
        tx_ready = 1'b0;
        issue(8'd0, 0, 1, 0, 0, 0);
        tick();
        check("stall_first_valid", tx_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("stall_hash", tx_data, 8'h23);
            tick();
        end
        tx_ready = 1'b1;
        wait_idle("idle_after_stall");

        // Start while busy is dropped with a single error pulse.
        issue(8'd42, 0, 0, 0, 0, 0);
        sender_data  = 8'd99;
        sender_start = 1'b1;
        tick();
        sender_start = 1'b0;
        check("drop_err_pulse", drop_err, 1);
        tick();
        check("drop_err_clear", drop_err, 0);
        wait_idle("idle_after_drop");

        // Reset after the second byte of "-128".
        base = hs_count;
        issue(8'h80, 0, 0, 0, 0, 0);
        n = 0;
        while (hs_count < base + 2 && n < 50) begin
            tick();
            n++;
        end
        check("abort_reached_two_bytes", hs_count - base, 2);
        rst      = 1'b1;
        tx_ready = 1'b0;
        tick();
        check("abort_tx_valid", tx_valid, 0);
        check("abort_busy", sender_busy, 0);
        exp_q.delete();
        rst      = 1'b0;
        tx_ready = 1'b1;
        tick();
        issue(8'd1, 0, 0, 0, 0, 0);
        wait_idle("idle_after_abort");

        // Randomized items with random back-pressure and gaps.
        rand_ready = 1'b1;
        repeat (150) begin
            issue(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, 1'($urandom));
            wait_idle("idle_random");
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_ready = 1'b0;
        tick();
        tx_ready = 1'b1;
        repeat (5) tick();

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_uart_sender.md
MATRIX_UART_SENDER -- requirements
Module: matrix_uart_sender

Interface
REQ-001 Clock and reset: one clock, clk; reset rst, synchronous, active-high.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 sender_start  in  1  one-cycle request to format and transmit one item.
REQ-005 sender_data  in  matrix_element_t  value to print: signed, ELEM_W=8, range -128..127.
REQ-006 sender_last_col  in  1  plain element is the last of its row.
REQ-007 sender_newline  in  1  item is a bare line break; sender_data is ignored.
REQ-008 sender_id  in  1  sender_data is a matrix ID.
REQ-009 sender_sum_head  in  1  sender_data is the summary total count.
REQ-010 sender_sum_elem  in  1  sender_data is a summary list entry.
REQ-011 tx_ready  in  1  byte UART transmitter can accept a byte.
REQ-012 tx_valid  out  1  tx_data holds a byte to transmit.
REQ-013 tx_data  out  8  ASCII byte.
REQ-014 sender_busy  out  1  high whenever the state is not IDLE.
REQ-015 drop_err  out  1  one-cycle pulse when a start is dropped.

Function
REQ-016 Item kind is decoded with priority newline > id > sum_head > sum_elem > plain element.
REQ-017 Number field: optional '-' (0x2D), then decimal magnitude 0..128 with leading zeros suppressed; zero prints as "0".
REQ-018 Byte strings by item kind:
 - newline: CR LF (0x0D 0x0A).
 - id: '#' + number + CR LF.
 - sum_head: "Total:" + number + CR LF.
 - sum_elem: number + ' ' (0x20).
 - plain: number + (last_col ? CR LF : ' ').
REQ-019 Byte buffer depth is 12, which holds the longest string ("Total:-128" CR LF). A byte index and a length register track transmission.
REQ-020 FSM states are IDLE, LOAD and SEND.
 - IDLE: on sender_start, latch sender_data and all flags, go to LOAD.
 - LOAD: fill the buffer and length from the latched item; go to SEND.
 - SEND: present buffer[index]; advance index on each tx_valid&&tx_ready; after the last byte's handshake go to IDLE.
REQ-021 Latency: start sampled in cycle N -> sender_busy=1 in N+1 -> first tx_valid=1 in N+2. After the final handshake, sender_busy=0 in the next cycle.
REQ-022 Handshake: a byte transfers only when tx_valid&&tx_ready. While tx_valid=1 and tx_ready=0, tx_data is held stable. tx_valid is never withdrawn before acceptance.
REQ-023 Back-to-back: a new start may be accepted in the first cycle in which the state is IDLE again.
REQ-024 Start while busy: the start is ignored, drop_err pulses for one cycle, and the in-flight item is unaffected.
REQ-025 Flags asserted without sender_start have no effect.
REQ-026 Minimum cost per item is 2 + byte count cycles with tx_ready held high.

Reset
REQ-027 On rst: state IDLE; tx_valid=0, tx_data=0, sender_busy=0, drop_err=0; index=0, length=0.
REQ-028 rst during SEND aborts the item at the next clock edge; no further tx_valid is issued for it.
REQ-029 Buffer contents after reset are don't-care and never transmitted.

Structure
REQ-030 matrix_element_t, ELEM_W and the ASCII constants (CR, LF, SPACE, MINUS, HASH) belong in project_pkg.
REQ-031 Decimal split is one combinational sub-module, elem_to_dec: signed element in; sign, hundreds, tens, ones and digit count (1..3) out.
REQ-032 The block drives no RAM address and no UART line; the bit-level serializer is external.

Verification
REQ-033 plain, data=5, last_col=0, tx_ready=1 -> bytes 0x35 0x20; sender_busy low 4 cycles after start.
REQ-034 plain, data=-128, last_col=1 -> 0x2D 0x31 0x32 0x38 0x0D 0x0A.
REQ-035 sum_head=1 and sum_elem=1, data=7 -> "Total:7" CR LF (priority check); newline=1 with id=1, data=3 -> 0x0D 0x0A only.
REQ-036 id, data=0, tx_ready low for 10 cycles after the first tx_valid -> tx_data stays 0x23 for the whole stall, then 0x23 0x30 0x0D 0x0A.
REQ-037 second start 1 cycle after the first (data=42) -> drop_err pulses once; output is exactly "42" + space.
REQ-038 rst asserted after the 2nd byte of "-128" -> tx_valid=0 next cycle, sender_busy=0; a following start with data=1 prints 0x31 0x20 cleanly.
